seq_feed_ctrl: RTL and testbench

Sequencing controller for the serial sequence detector on the Basys3 lab board. It latches a WIDTH-bit word from the switches together with the mode button and flushes the detector to its idle state. It then streams the word MSB-first into the detector's serial input, one bit per clock, and counts the detector's match pulses. Results go to LEDs and the seven-segment display.

---
 rtl/seq_feed_ctrl.sv | 162 ++++++++++++++++
 tb/tb_seq_feed_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_feed_ctrl.sv
// Feeds a latched switch word MSB-first into the serial sequence detector and counts its match pulses.
// Optional detector flush before each run is enabled by defining SEQ_FEED_FLUSH_EN.
module seq_feed_ctrl #(
    parameter int WIDTH     = 16,
    parameter int FLUSH_LEN = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             BTN,
    input  logic [WIDTH-1:0] DIN,
    input  logic             Z_IN,
    output logic             X_OUT,
    output logic             BTN_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [3:0]       HIT_CNT,
    output logic             HIT
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FLUSH = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH < 2 || WIDTH > 16 || FLUSH_LEN < 4) begin : g_bad_param
        $error("seq_feed_ctrl: WIDTH must be 2..16 and FLUSH_LEN at least 4");
    end

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       hit_nxt;
    logic             sample_z;
    logic             last_bit;

`ifdef SEQ_FEED_FLUSH_EN
    localparam int FW = $clog2(FLUSH_LEN);

    logic [FW-1:0] flush_cnt;
    logic          last_flush;

    assign last_flush = (flush_cnt == FW'(FLUSH_LEN - 1));
`endif

    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        sample_z  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
`ifdef SEQ_FEED_FLUSH_EN
                    state_nxt = ST_FLUSH;
`else
                    state_nxt = ST_SHIFT;
`endif
                end
            end
`ifdef SEQ_FEED_FLUSH_EN
            ST_FLUSH: begin
                if (last_flush) begin
                    state_nxt = ST_SHIFT;
                end
            end
`endif
            ST_SHIFT: begin
                // Z is one cycle behind X, so the first shift cycle still shows flush/idle history.
                sample_z = (bit_cnt != '0);
                if (last_bit) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                sample_z  = 1'b1;
                state_nxt = ST_FIN;
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        hit_nxt = HIT_CNT;
        if (state == ST_IDLE && START) begin
            hit_nxt = 4'd0;
        end else if (sample_z && Z_IN && HIT_CNT != 4'hF) begin
            hit_nxt = HIT_CNT + 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
`ifdef SEQ_FEED_FLUSH_EN
            flush_cnt <= '0;
`endif
            X_OUT     <= 1'b1;
            BTN_OUT   <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            HIT_CNT   <= 4'd0;
            HIT       <= 1'b0;
        end else begin
            state   <= state_nxt;
            HIT_CNT <= hit_nxt;
            HIT     <= (hit_nxt != 4'd0);
            BUSY    <= (state_nxt != ST_IDLE);
            DONE    <= (state_nxt == ST_FIN);

            case (state)
                ST_IDLE: begin
                    X_OUT <= 1'b1;
                    if (START) begin
                        BTN_OUT <= BTN;
                        bit_cnt <= '0;
`ifdef SEQ_FEED_FLUSH_EN
                        shift_reg <= DIN;
                        flush_cnt <= '0;
`else
                        // Without flush the first data bit must already be on X in the next cycle.
                        X_OUT     <= DIN[WIDTH-1];
                        shift_reg <= {DIN[WIDTH-2:0], 1'b0};
`endif
                    end
                end
`ifdef SEQ_FEED_FLUSH_EN
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (last_flush) begin
                        X_OUT     <= shift_reg[WIDTH-1];
                        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                        bit_cnt   <= '0;
                    end else begin
                        X_OUT <= 1'b1;
                    end
                end
`endif
                ST_SHIFT: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        X_OUT <= 1'b1;
                    end else begin
                        X_OUT     <= shift_reg[WIDTH-1];
                        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    end
                end
                default: begin
                    X_OUT <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_feed_ctrl.sv
// Self-checking bench for seq_feed_ctrl with a sliding-window model of the external sequence detector.
module tb_seq_feed_ctrl;

    localparam int W = 16;
`ifdef SEQ_FEED_FLUSH_EN
    localparam int FL = 5;
`else
    localparam int FL = 0;
`endif
    localparam int LAT = FL + W + 1;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic         BTN = 1'b0;
    logic [W-1:0] DIN = '0;
    logic         Z_IN;
    logic         X_OUT;
    logic         BTN_OUT;
    logic         BUSY;
    logic         DONE;
    logic [3:0]   HIT_CNT;
    logic         HIT;

    int n_cmp  = 0;
    int n_fail = 0;

    // Z source: 0 = detector model, 1 = constant 1, 2 = per-cycle table zv[] indexed by cycles since START edge
    int         z_mode = 0;
    logic       z_drive = 1'b0;
    logic       zv [0:LAT+8];
    logic [5:0] hist = 6'h3F;
    logic       plant_req = 1'b0;
    logic [5:0] plant_val = 6'h3F;
    logic       det_z;

    seq_feed_ctrl #(.WIDTH(W), .FLUSH_LEN(5)) dut (
        .CLK(CLK), .RST(RST), .START(START), .BTN(BTN), .DIN(DIN), .Z_IN(Z_IN),
        .X_OUT(X_OUT), .BTN_OUT(BTN_OUT), .BUSY(BUSY), .DONE(DONE),
        .HIT_CNT(HIT_CNT), .HIT(HIT)
    );

    always #5 CLK = ~CLK;

    // Detector model: the last six bits it received, oldest at the MSB; Moore output on a full match.
    always @(posedge CLK) begin
        if (plant_req) hist <= plant_val;
        else           hist <= {hist[4:0], X_OUT};
    end
    assign det_z = (hist == (BTN_OUT ? 6'b011101 : 6'b011001));
    assign Z_IN  = (z_mode == 0) ? det_z : z_drive;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    function automatic int ref_hits(input logic [W-1:0] d, input logic mode);
        logic [5:0] pat;
        int c;
        pat = mode ? 6'b011101 : 6'b011001;
        c = 0;
        for (int k = W - 1; k >= 5; k--) begin
            if (d[k -: 6] == pat) c++;
        end
        return (c > 15) ? 15 : c;
    endfunction

    task automatic launch(input logic [W-1:0] din, input logic btn);
        repeat (6) @(posedge CLK);
        #1;
        DIN = din;
        BTN = btn;
        START = 1'b1;
        if (z_mode == 2) z_drive = zv[0];
        @(posedge CLK);
        #1;
        START = 1'b0;
        plant_req = 1'b0;
        if (z_mode == 2) z_drive = zv[1];
    endtask

    // Runs from just after the START edge through the first IDLE cycle; hold keeps START high in FIN and IDLE.
    task automatic finish_run(input string name, input logic btn, input int exp_hits,
                              input bit disturb, input bit hold);
        bit seen;
        int n;
        seen = 1'b0;
        n = 0;
        while (!seen && n < LAT + 3) begin
            n++;
            @(posedge CLK);
            #1;
            if (z_mode == 2) z_drive = zv[n+1];
            if (DONE === 1'b1) begin
                seen = 1'b1;
                n_cmp++;
                if (n != LAT) begin
                    n_fail++;
                    $display("FAIL %s latency: DONE after %0d cycles, expected %0d", name, n, LAT);
                end
                n_cmp++;
                if (HIT_CNT !== 4'(exp_hits)) begin
                    n_fail++;
                    $display("FAIL %s hit_cnt: got %0d expected %0d", name, HIT_CNT, exp_hits);
                end
                n_cmp++;
                if (HIT !== (exp_hits != 0)) begin
                    n_fail++;
                    $display("FAIL %s hit: got %b expected %b", name, HIT, exp_hits != 0);
                end
                n_cmp++;
                if (BTN_OUT !== btn || BUSY !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s fin_flags: btn_out=%b busy=%b expected btn_out=%b busy=1",
                             name, BTN_OUT, BUSY, btn);
                end
                START = hold;
            end else begin
                n_cmp++;
                if (BUSY !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy cycle %0d: got %b expected 1", name, n, BUSY);
                end
                if (disturb) begin
                    START = 1'($urandom);
                    DIN   = W'($urandom);
                    BTN   = 1'($urandom);
                end
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: no DONE within %0d cycles, expected at %0d", name, LAT + 3, LAT);
            START = 1'b0;
        end
        @(posedge CLK);
        #1;
        n_cmp++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || HIT_CNT !== 4'(exp_hits)) begin
            n_fail++;
            $display("FAIL %s after_fin: done=%b busy=%b hit_cnt=%0d expected 0 0 %0d",
                     name, DONE, BUSY, HIT_CNT, exp_hits);
        end
        if (!hold) START = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        n_cmp++;
        if (X_OUT !== 1'b1 || BTN_OUT !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 ||
            HIT_CNT !== 4'd0 || HIT !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: x=%b btn_out=%b busy=%b done=%b hit_cnt=%0d hit=%b expected 1 0 0 0 0 0",
                     name, X_OUT, BTN_OUT, BUSY, DONE, HIT_CNT, HIT);
        end
    endtask

    task automatic test_reset();
        #12;
        check_reset_values("reset");
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_pattern_modes();
        z_mode = 0;
        launch(16'h6400, 1'b0);
        finish_run("mode0_6400", 1'b0, 1, 1'b0, 1'b0);
        launch(16'h7400, 1'b1);
        finish_run("mode1_7400", 1'b1, 1, 1'b0, 1'b0);
        launch(16'h6400, 1'b1);
        finish_run("mode1_6400", 1'b1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_overlap();
        z_mode = 0;
        launch(16'h6590, 1'b0);
        finish_run("overlap_6590", 1'b0, 2, 1'b0, 1'b0);
        launch(16'h0019, 1'b0);
        finish_run("last_bit_0019", 1'b0, 1, 1'b0, 1'b0);
    endtask

`ifdef SEQ_FEED_FLUSH_EN
    task automatic test_dirty_detector();
        z_mode = 0;
        plant_val = 6'b110111;
        plant_req = 1'b1;
        launch(16'h6400, 1'b0);
        finish_run("dirty_6400", 1'b0, 1, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_random_patterns();
        logic [W-1:0] d;
        logic         b;
        int           pos;
        z_mode = 0;
        for (int i = 0; i < 12; i++) begin
            d = W'($urandom);
            b = 1'($urandom);
            if (i % 2 == 0) begin
                pos = $urandom_range(W - 1, 5);
                d[pos -: 6] = b ? 6'b011101 : 6'b011001;
            end
            launch(d, b);
            finish_run($sformatf("random_%0d_%h_%b", i, d, b), b, ref_hits(d, b), 1'b0, 1'b0);
        end
    endtask

    task automatic test_z_window();
        int exp;
        z_mode = 2;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k <= LAT + 8; k++) zv[k] = 1'($urandom);
            exp = 0;
            for (int k = FL + 2; k <= FL + W + 1; k++) exp += int'(zv[k]);
            if (exp > 15) exp = 15;
            launch(W'($urandom), 1'($urandom));
            finish_run($sformatf("z_window_%0d", r), BTN, exp, 1'b0, 1'b0);
        end
        z_mode = 0;
    endtask

    task automatic test_saturation();
        z_mode = 1;
        z_drive = 1'b1;
        launch(16'hA5A5, 1'b1);
        finish_run("saturation", 1'b1, 15, 1'b0, 1'b0);
        z_mode = 0;
    endtask

    task automatic test_ignored_inputs();
        z_mode = 0;
        launch(16'h6400, 1'b0);
        finish_run("ignored_inputs", 1'b0, 1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d1, d2;
        logic         b1, b2;
        z_mode = 0;
        // A trailing 1 plus DRAIN/FIN/IDLE gives the detector four 1s even without a flush.
        d1 = W'($urandom) | W'(1);
        d2 = 16'h6590;
        b1 = 1'($urandom);
        b2 = 1'b0;
        launch(d1, b1);
        finish_run("b2b_first", b1, ref_hits(d1, b1), 1'b0, 1'b1);
        DIN = d2;
        BTN = b2;
        @(posedge CLK);
        #1;
        START = 1'b0;
        finish_run("b2b_second", b2, ref_hits(d2, b2), 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        z_mode = 1;
        z_drive = 1'b1;
        launch(16'h0000, 1'b1);
        repeat (FL + 5) @(posedge CLK);
        #1;
        n_cmp++;
        if (HIT_CNT !== 4'd4 || X_OUT !== 1'b0 || BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_run_state: hit_cnt=%0d x=%b busy=%b expected 4 0 1", HIT_CNT, X_OUT, BUSY);
        end
        RST = 1'b1;
        #1;
        check_reset_values("reset_mid_run");
        @(negedge CLK);
        RST = 1'b0;
        z_mode = 0;
        launch(16'h6400, 1'b0);
        finish_run("after_abort_6400", 1'b0, 1, 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k <= LAT + 8; k++) zv[k] = 1'b0;
        test_reset();
        test_pattern_modes();
        test_overlap();
`ifdef SEQ_FEED_FLUSH_EN
        test_dirty_detector();
`endif
        test_random_patterns();
        test_z_window();
        test_saturation();
        test_ignored_inputs();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
